// File: rtl/ddr_write_master_pkg.sv
// Shared constants and FSM encoding for the DDR write master and its bench.
package ddr_write_master_pkg;
  localparam int         AXI_WIDTH_DATA_IN = 128;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         BYTES_PER_BEAT    = AXI_WIDTH_DATA_IN / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } wm_state_e;

  function automatic int beat_bytes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
module sync_fifo_fwft #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      // Push and pop together leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ddr_write_master.sv
// Buffers the output feature stream and writes it to DDR as AXI4 INCR bursts,
// one burst outstanding at a time, then pulses Write_Complete.
module ddr_write_master
  import ddr_write_master_pkg::*;
#(
  parameter int DATA_WIDTH     = AXI_WIDTH_DATA_IN,
  parameter int ADDR_WIDTH     = 32,
  parameter int BEAT_NUM_WIDTH = 24,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Start,
  input  logic [ADDR_WIDTH-1:0]     Base_Addr,
  input  logic [BEAT_NUM_WIDTH-1:0] Beat_Num,
  input  logic [DATA_WIDTH-1:0]     S_Data,
  input  logic                      S_Valid,
  output logic                      S_Ready,
  input  logic                      S_Last,
  output logic [ADDR_WIDTH-1:0]     M_AWADDR,
  output logic [7:0]                M_AWLEN,
  output logic                      M_AWVALID,
  input  logic                      M_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
  output logic                      M_WLAST,
  output logic                      M_WVALID,
  input  logic                      M_WREADY,
  input  logic [1:0]                M_BRESP,
  input  logic                      M_BVALID,
  output logic                      M_BREADY,
  output logic                      Busy,
  output logic                      Write_Complete,
  output logic                      Err,
  output logic [2:0]                Dbg_State
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BEAT_NUM_WIDTH-1:0] BURST_LEN_B  = BEAT_NUM_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]     BEAT_BYTES_A = ADDR_WIDTH'(beat_bytes(DATA_WIDTH));

  wm_state_e                 r_state;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [ADDR_WIDTH-1:0]     r_awaddr;
  logic [7:0]                r_awlen;
  logic [7:0]                r_wbeat;
  logic [BEAT_NUM_WIDTH-1:0] r_beat_num;
  logic [BEAT_NUM_WIDTH-1:0] r_acc_cnt;
  logic [BEAT_NUM_WIDTH-1:0] r_remaining;
  logic [BEAT_NUM_WIDTH-1:0] r_blen;
  logic                      r_awvalid;
  logic                      r_bready;
  logic                      r_busy;
  logic                      r_wc;
  logic                      r_err;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_wvalid;
  logic                      w_wlast;
  logic                      w_last_beat;
  logic [CNT_W-1:0]          w_count;
  logic [BEAT_NUM_WIDTH-1:0] w_fifo_cnt;
  logic [BEAT_NUM_WIDTH-1:0] w_blen;
  logic [DATA_WIDTH-1:0]     w_fifo_dout;

  // Every channel transfers on the cycle where valid && ready are both high;
  // a valid, once raised, is held with its payload stable until that cycle.
  assign S_Ready     = r_busy && !w_full && (r_acc_cnt < r_beat_num);
  assign w_push      = S_Valid && S_Ready;
  assign w_last_beat = (r_acc_cnt == r_beat_num - BEAT_NUM_WIDTH'(1));
  assign w_wvalid    = (r_state == ST_DATA) && !w_empty;
  assign w_wlast     = w_wvalid && (r_wbeat == r_awlen);
  assign w_pop       = w_wvalid && M_WREADY;
  assign w_fifo_cnt  = BEAT_NUM_WIDTH'(w_count);
  assign w_blen      = (r_remaining > BURST_LEN_B) ? BURST_LEN_B : r_remaining;

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (S_Data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_wbeat     <= '0;
      r_beat_num  <= '0;
      r_acc_cnt   <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_wc        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wc <= 1'b0;
      if (w_push) begin
        r_acc_cnt <= r_acc_cnt + BEAT_NUM_WIDTH'(1);
        if (S_Last != w_last_beat) r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_err       <= 1'b0;
            r_beat_num  <= Beat_Num;
            r_remaining <= Beat_Num;
            r_addr      <= Base_Addr;
            r_acc_cnt   <= '0;
            if (Beat_Num == '0) begin
              r_wc <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // Issue the burst only once all of its beats are buffered.
          if (!r_awvalid) begin
            if (w_fifo_cnt >= w_blen) begin
              r_awvalid <= 1'b1;
              r_awaddr  <= r_addr;
              r_awlen   <= 8'(w_blen - BEAT_NUM_WIDTH'(1));
              r_blen    <= w_blen;
            end
          end else if (M_AWREADY) begin
            r_awvalid <= 1'b0;
            r_wbeat   <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_pop) begin
            r_wbeat <= r_wbeat + 8'd1;
            if (w_wlast) begin
              r_bready <= 1'b1;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (M_BVALID) begin
            r_bready    <= 1'b0;
            if (M_BRESP != AXI_RESP_OKAY) r_err <= 1'b1;
            r_remaining <= r_remaining - r_blen;
            r_addr      <= r_addr + ADDR_WIDTH'(r_blen) * BEAT_BYTES_A;
            if (r_remaining == r_blen) begin
              r_busy  <= 1'b0;
              r_wc    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign M_AWADDR       = r_awaddr;
  assign M_AWLEN        = r_awlen;
  assign M_AWVALID      = r_awvalid;
  assign M_WDATA        = w_fifo_dout;
  assign M_WSTRB        = '1;
  assign M_WLAST        = w_wlast;
  assign M_WVALID       = w_wvalid;
  assign M_BREADY       = r_bready;
  assign Busy           = r_busy;
  assign Write_Complete = r_wc;
  assign Err            = r_err;
  assign Dbg_State      = r_state;
endmodule
